// File: rtl/core_mau_ctrl_if.sv
// Exec-stage request, MAU-side and data-bus signals of the MAU controller.
interface core_mau_ctrl_if;
    logic        req_vld_i;
    logic        req_rdy_o;
    logic [4:0]  req_func_i;
    logic [31:0] req_addr_i;
    logic [5:0]  mau_func_o;
    logic [1:0]  mau_addr_o;
    logic [31:0] mau_rdata_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    // Controller side
    modport slave (
        input  req_vld_i, req_func_i, req_addr_i, bus_ack_i, bus_rdata_i,
        output req_rdy_o, mau_func_o, mau_addr_o, mau_rdata_o, bus_req_o,
        output bus_addr_o, stall_o, done_o, err_o, err_code_o
    );

    // Exec stage / bus side
    modport master (
        output req_vld_i, req_func_i, req_addr_i, bus_ack_i, bus_rdata_i,
        input  req_rdy_o, mau_func_o, mau_addr_o, mau_rdata_o, bus_req_o,
        input  bus_addr_o, stall_o, done_o, err_o, err_code_o
    );
endinterface

// File: rtl/core_mau_ctrl.sv
// MAU sequencer: one load/store in flight between exec stage and data bus.
// func = {unsigned, size[1:0], load, store}; size 01 = byte, 10 = half,
// 00 = word, 11 = illegal.
module core_mau_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input logic          clk_i,
    input logic          rst_n_i,
    core_mau_ctrl_if.slave m
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, ACC, RESP, DONE, ERR} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size;
    logic             illegal;
    logic             misal;

    // Request decode for the accept decision in IDLE
    always_comb begin
        size    = m.req_func_i[3:2];
        illegal = (m.req_func_i[1] == m.req_func_i[0]) || (size == 2'b11);
        misal   = ((size == 2'b10) && m.req_addr_i[0]) ||
                  ((size == 2'b00) && (m.req_addr_i[1:0] != 2'b00));
    end

    assign m.req_rdy_o = (state == IDLE);

    // Sequencer with registered outputs; pulses default low every cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            cnt           <= '0;
            m.mau_func_o  <= '0;
            m.mau_addr_o  <= '0;
            m.mau_rdata_o <= '0;
            m.bus_req_o   <= 1'b0;
            m.bus_addr_o  <= '0;
            m.stall_o     <= 1'b0;
            m.done_o      <= 1'b0;
            m.err_o       <= 1'b0;
            m.err_code_o  <= '0;
        end else begin
            m.done_o <= 1'b0;
            m.err_o  <= 1'b0;
            case (state)
                IDLE: if (m.req_vld_i) begin
                    if (illegal) begin
                        state        <= ERR;
                        m.err_o      <= 1'b1;
                        m.err_code_o <= 2'b11;
                    end else if (misal) begin
                        state        <= ERR;
                        m.err_o      <= 1'b1;
                        m.err_code_o <= 2'b01;
                    end else begin
                        state        <= ACC;
                        cnt          <= '0;
                        m.bus_req_o  <= 1'b1;
                        m.bus_addr_o <= {m.req_addr_i[31:2], 2'b00};
                        m.mau_func_o <= {1'b0, m.req_func_i};
                        m.mau_addr_o <= m.req_addr_i[1:0];
                        m.stall_o    <= 1'b1;
                    end
                end
                ACC: begin
                    if (m.bus_ack_i) begin
                        // ack beats a timeout landing in the same cycle
                        m.bus_req_o <= 1'b0;
                        m.stall_o   <= 1'b0;
                        m.done_o    <= 1'b1;
                        if (m.mau_func_o[1]) begin
                            state            <= RESP;
                            m.mau_rdata_o    <= m.bus_rdata_i;
                            m.mau_func_o[5]  <= 1'b1;
                        end else begin
                            state        <= DONE;
                            m.mau_func_o <= '0;
                            m.mau_addr_o <= '0;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state        <= ERR;
                        m.bus_req_o  <= 1'b0;
                        m.stall_o    <= 1'b0;
                        m.mau_func_o <= '0;
                        m.mau_addr_o <= '0;
                        m.err_o      <= 1'b1;
                        m.err_code_o <= 2'b10;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    m.mau_func_o <= '0;
                    m.mau_addr_o <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_mau_ctrl.sv
// Directed bench for core_mau_ctrl with a completion scoreboard.
module tb_core_mau_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    core_mau_ctrl_if m ();

    core_mau_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .m(m.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        bit          is_load;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Completion monitor: every done/err pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && (m.done_o || m.err_o)) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {30'd0, m.done_o, m.err_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_is_err", {31'd0, m.err_o}, {31'd0, e.is_err});
                chk("out_done", {31'd0, m.done_o}, {31'd0, !e.is_err});
                chk("out_cycle", cyc, e.cyc);
                if (e.is_err) begin
                    chk("err_code", {30'd0, m.err_code_o}, {30'd0, e.code});
                    chk("err_bus_req", {31'd0, m.bus_req_o}, 32'd0);
                end else if (e.is_load) begin
                    chk("resp_phase", {31'd0, m.mau_func_o[5]}, 32'd1);
                    chk("resp_rdata", m.mau_rdata_o, e.rdata);
                    chk("resp_stall", {31'd0, m.stall_o}, 32'd0);
                end else begin
                    chk("done_func", {26'd0, m.mau_func_o}, 32'd0);
                    chk("done_stall", {31'd0, m.stall_o}, 32'd0);
                end
            end
        end
    end

    // One request; waits<0 means the bus never acks. code: 0 ok, else expected error.
    task automatic run(input logic [4:0] f, input logic [31:0] a, input int waits,
                       input logic [31:0] rd, input logic [1:0] code,
                       output int req_cyc, output int stall_cyc);
        exp_t x;
        int   t;
        @(posedge clk); #1;
        m.req_vld_i = 1'b1; m.req_func_i = f; m.req_addr_i = a;
        t = cyc;
        x.is_err = (code != 2'b00); x.code = code; x.is_load = f[1]; x.rdata = rd;
        if (code == 2'b00)      x.cyc = t + 2 + waits;
        else if (code == 2'b10) x.cyc = t + 1 + TO;
        else                    x.cyc = t + 1;
        sb.push_back(x);
        @(posedge clk); #1;
        m.req_vld_i = 1'b0;
        req_cyc = 0; stall_cyc = 0;
        for (int c = 0; c < 12; c++) begin
            m.bus_ack_i   = (waits >= 0) && (c == waits);
            m.bus_rdata_i = (c == waits) ? rd : 32'h0;
            @(negedge clk);
            if (c == 0 && (code == 2'b00 || code == 2'b10)) begin
                chk("acc_bus_addr", m.bus_addr_o, {a[31:2], 2'b00});
                chk("acc_func", {26'd0, m.mau_func_o}, {26'd0, 1'b0, f});
                chk("acc_addr", {30'd0, m.mau_addr_o}, {30'd0, a[1:0]});
                chk("acc_rdy", {31'd0, m.req_rdy_o}, 32'd0);
            end
            if (m.bus_req_o) req_cyc++;
            if (m.stall_o) stall_cyc++;
            @(posedge clk); #1;
            m.bus_ack_i = 1'b0;
        end
    endtask

    int rq, st;

    initial begin
        m.req_vld_i = 1'b0; m.req_func_i = '0; m.req_addr_i = '0;
        m.bus_ack_i = 1'b0; m.bus_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", {31'd0, m.req_rdy_o}, 32'd1);
        chk("rst_bus_req", {31'd0, m.bus_req_o}, 32'd0);
        chk("rst_func", {26'd0, m.mau_func_o}, 32'd0);
        chk("rst_stall", {31'd0, m.stall_o}, 32'd0);
        chk("rst_code", {30'd0, m.err_code_o}, 32'd0);
        chk("rst_rdata", m.mau_rdata_o, 32'd0);

        // word load, zero wait
        run(5'b00010, 32'h1000_0004, 0, 32'hDEAD_BEEF, 2'b00, rq, st);
        chk("wl_req_cyc", rq, 1); chk("wl_stall_cyc", st, 1);
        // byte store, three waits
        run(5'b00101, 32'h1000_0003, 3, 32'h0, 2'b00, rq, st);
        chk("bs_req_cyc", rq, 4); chk("bs_stall_cyc", st, 4);
        chk("bs_rdata_held", m.mau_rdata_o, 32'hDEAD_BEEF);
        // misaligned half load
        run(5'b01010, 32'h1000_0001, -1, 32'h0, 2'b01, rq, st);
        chk("mh_req_cyc", rq, 0); chk("mh_stall_cyc", st, 0);
        // load and store both set
        run(5'b00011, 32'h1000_0000, -1, 32'h0, 2'b11, rq, st);
        chk("ls_req_cyc", rq, 0);
        // size 11
        run(5'b01110, 32'h1000_0000, -1, 32'h0, 2'b11, rq, st);
        chk("sz_req_cyc", rq, 0);
        // misaligned word store
        run(5'b00001, 32'h1000_0002, -1, 32'h0, 2'b01, rq, st);
        chk("mw_req_cyc", rq, 0);
        // timeout
        run(5'b00010, 32'h2000_0008, -1, 32'h0, 2'b10, rq, st);
        chk("to_req_cyc", rq, TO); chk("to_stall_cyc", st, TO);
        chk("to_code_held", {30'd0, m.err_code_o}, 32'd2);
        // ack on the last allowed cycle wins
        run(5'b10010, 32'h2000_000C, TO - 1, 32'h1234_5678, 2'b00, rq, st);
        chk("la_req_cyc", rq, TO);
        // aligned half store, one wait
        run(5'b01001, 32'h3000_0002, 1, 32'h0, 2'b00, rq, st);
        chk("hs_req_cyc", rq, 2);
        chk("hs_rdata_held", m.mau_rdata_o, 32'h1234_5678);

        // async reset while in ACC
        @(posedge clk); #1;
        m.req_vld_i = 1'b1; m.req_func_i = 5'b00010; m.req_addr_i = 32'h4000_0000;
        @(posedge clk); #1;
        m.req_vld_i = 1'b0;
        chk("ar_pre_req", {31'd0, m.bus_req_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_bus_req", {31'd0, m.bus_req_o}, 32'd0);
        chk("ar_stall", {31'd0, m.stall_o}, 32'd0);
        chk("ar_rdy", {31'd0, m.req_rdy_o}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        run(5'b00010, 32'h4000_0010, 2, 32'hCAFE_F00D, 2'b00, rq, st);
        chk("ar_req_cyc", rq, 3);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
